// File: rtl/bist_pkg.sv
// Shared BIST definitions: run-state encoding, MISR feedback polynomial and
// the default golden signature used when a CUT-specific value is not supplied.
package bist_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COMPACT = 2'd1,
        ST_DONE    = 2'd2
    } bist_state_e;

    // CRC-CCITT polynomial x^16 + x^12 + x^5 + 1
    localparam logic [15:0] MISR_TAP_CCITT     = 16'h1021;
    localparam logic [15:0] DEFAULT_GOLDEN_SIG = 16'h0000;

endpackage

// File: rtl/misr_core.sv
// Multiple-input signature register: shift-left Galois MISR with response
// injection on the low IN_LEN bits; exposes the next value for the pass compare.
module misr_core
    import bist_pkg::*;
#(
    parameter int unsigned          IN_LEN  = 7,
    parameter int unsigned          SIG_LEN = 16,
    parameter logic [SIG_LEN-1:0]   TAP     = SIG_LEN'(MISR_TAP_CCITT)
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                clr,
    input  logic                en,
    input  logic [IN_LEN-1:0]   din,
    output logic [SIG_LEN-1:0]  sig_next,
    output logic [SIG_LEN-1:0]  sig
);

    logic [SIG_LEN-1:0] sig_q;
    logic [SIG_LEN-1:0] sig_d;
    logic [SIG_LEN-1:0] din_ext;
    logic [SIG_LEN-1:0] nxt;
    logic               fb;

    always_comb begin
        din_ext             = '0;
        din_ext[IN_LEN-1:0] = din;
        fb                  = sig_q[SIG_LEN-1];
        nxt                 = '0;
        // Bit 0 always takes the feedback, independent of TAP[0]
        nxt[0]              = fb ^ din_ext[0];
        for (int unsigned i = 1; i < SIG_LEN; i++) begin
            nxt[i] = sig_q[i-1] ^ (TAP[i] & fb) ^ din_ext[i];
        end
    end

    always_comb begin
        sig_d = sig_q;
        if (clr) begin
            sig_d = '0;
        end else if (en) begin
            sig_d = nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sig_q <= '0;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign sig_next = nxt;
    assign sig      = sig_q;

endmodule

// File: rtl/misr_response_analyzer.sv
// BIST output response analyzer: compacts NUM_PATTERNS CUT responses into a
// MISR, then holds the final signature and its comparison against GOLDEN_SIG.
module misr_response_analyzer
    import bist_pkg::*;
#(
    parameter int unsigned          IN_LEN       = 7,
    parameter int unsigned          SIG_LEN      = 16,
    parameter int unsigned          NUM_PATTERNS = 127,
    parameter logic [SIG_LEN-1:0]   GOLDEN_SIG   = SIG_LEN'(DEFAULT_GOLDEN_SIG)
) (
    input  logic                                clk,
    input  logic                                reset_n,
    input  logic                                start,
    input  logic                                in_valid,
    input  logic [IN_LEN-1:0]                   din,
    output logic                                busy,
    output logic                                done,
    output logic                                pass,
    output logic [SIG_LEN-1:0]                  signature,
    output logic [$clog2(NUM_PATTERNS+1)-1:0]   pat_cnt
);

    localparam int unsigned       CNT_W    = $clog2(NUM_PATTERNS + 1);
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(NUM_PATTERNS - 1);

    bist_state_e        state_q;
    bist_state_e        state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;
    logic               done_q;
    logic               done_d;
    logic               pass_q;
    logic               pass_d;

    logic               start_run;
    logic               accept;
    logic               final_rsp;
    logic               busy_w;
    logic [SIG_LEN-1:0] sig_next;

    misr_core #(
        .IN_LEN  (IN_LEN),
        .SIG_LEN (SIG_LEN),
        .TAP     (SIG_LEN'(MISR_TAP_CCITT))
    ) u_misr (
        .clk      (clk),
        .reset_n  (reset_n),
        .clr      (start_run),
        .en       (accept),
        .din      (din),
        .sig_next (sig_next),
        .sig      (signature)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_run) begin
                    state_d = ST_COMPACT;
                end
            end
            ST_COMPACT: begin
                if (final_rsp) begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output / control decode; start is only honoured outside COMPACT
    always_comb begin
        busy_w    = (state_q == ST_COMPACT);
        start_run = start && !busy_w;
        accept    = busy_w && in_valid;
        final_rsp = accept && (cnt_q == LAST_CNT);
    end

    // Pattern counter and result flags
    always_comb begin
        cnt_d  = cnt_q;
        done_d = done_q;
        pass_d = pass_q;
        if (start_run) begin
            cnt_d  = '0;
            done_d = 1'b0;
            pass_d = 1'b0;
        end else if (accept) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (final_rsp) begin
                done_d = 1'b1;
                pass_d = (sig_next == GOLDEN_SIG);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_q  <= '0;
            done_q <= 1'b0;
            pass_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            done_q <= done_d;
            pass_q <= pass_d;
        end
    end

    assign busy    = busy_w;
    assign done    = done_q;
    assign pass    = pass_q;
    assign pat_cnt = cnt_q;

endmodule

// File: tb/tb_misr_response_analyzer.sv
// Randomized self-checking bench for misr_response_analyzer against a
// polynomial-arithmetic reference model, plus fixed-vector checks on small runs.
module tb_misr_response_analyzer;

    localparam int NP0 = 127;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n;

    // Main DUT: defaults (127 patterns, golden 0)
    logic        st0, v0;
    logic [6:0]  d0;
    logic        busy0, done0, pass0;
    logic [15:0] sig0;
    logic [6:0]  cnt0;

    // Small DUTs: 4 patterns, 1 pattern, 17 patterns (golden 0x1021)
    logic        sta, va, stb, vb, stc, vc;
    logic [6:0]  da, db, dc;
    logic        busya, donea, passa, busyb, doneb, passb, busyc, donec, passc;
    logic [15:0] siga, sigb, sigc;
    logic [2:0]  cnta;
    logic [0:0]  cntb;
    logic [4:0]  cntc;

    misr_response_analyzer u_dut0 (
        .clk(clk), .reset_n(reset_n), .start(st0), .in_valid(v0), .din(d0),
        .busy(busy0), .done(done0), .pass(pass0), .signature(sig0), .pat_cnt(cnt0)
    );

    misr_response_analyzer #(.NUM_PATTERNS(4)) u_dut4 (
        .clk(clk), .reset_n(reset_n), .start(sta), .in_valid(va), .din(da),
        .busy(busya), .done(donea), .pass(passa), .signature(siga), .pat_cnt(cnta)
    );

    misr_response_analyzer #(.NUM_PATTERNS(1)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .start(stb), .in_valid(vb), .din(db),
        .busy(busyb), .done(doneb), .pass(passb), .signature(sigb), .pat_cnt(cntb)
    );

    misr_response_analyzer #(.NUM_PATTERNS(17), .GOLDEN_SIG(16'h1021)) u_dut17 (
        .clk(clk), .reset_n(reset_n), .start(stc), .in_valid(vc), .din(dc),
        .busy(busyc), .done(donec), .pass(passc), .signature(sigc), .pat_cnt(cntc)
    );

    int unsigned n_total = 0;
    int unsigned n_pass  = 0;

    // Reference model of the main DUT
    bit          m_run;
    logic [15:0] m_sig;
    int          m_cnt;
    bit          m_done, m_pass;

    // Signature as polynomial: multiply by x modulo x^16+x^12+x^5+1, add response
    function automatic logic [15:0] misr_step(input logic [15:0] s, input logic [6:0] d);
        logic [16:0] prod;
        prod = {s, 1'b0};
        if (prod[16]) prod = prod ^ 17'h11021;
        return prod[15:0] ^ {9'd0, d};
    endfunction

    task automatic model_step(input logic rst_n, input logic st, input logic v, input logic [6:0] d);
        if (!rst_n) begin
            m_run = 0; m_sig = '0; m_cnt = 0; m_done = 0; m_pass = 0;
        end else if (st && !m_run) begin
            m_run = 1; m_sig = '0; m_cnt = 0; m_done = 0; m_pass = 0;
        end else if (m_run && v) begin
            m_sig = misr_step(m_sig, d);
            m_cnt = m_cnt + 1;
            if (m_cnt == NP0) begin
                m_run  = 0;
                m_done = 1;
                m_pass = (m_sig == 16'h0000);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc0();
        tick();
        model_step(reset_n, st0, v0, d0);
    endtask

    function automatic logic [25:0] exp0();
        return {m_run, m_done, m_pass, m_sig, 7'(m_cnt)};
    endfunction

    task automatic idle_small();
        sta = 0; va = 0; da = '0;
        stb = 0; vb = 0; db = '0;
        stc = 0; vc = 0; dc = '0;
    endtask

    task automatic test_reset();
        st0 = 1; v0 = 1; d0 = 7'h55;
        sta = 1; va = 1; da = 7'h7F;
        stb = 1; vb = 1; db = 7'h7F;
        stc = 1; vc = 1; dc = 7'h7F;
        reset_n = 0;
        cyc0();
        cyc0();
        n_total++;
        if ({busy0, done0, pass0, sig0, cnt0} !== 26'd0)
            $display("FAIL reset_main: got %h want 0", {busy0, done0, pass0, sig0, cnt0});
        else n_pass++;
        n_total++;
        if ({busya, donea, passa, siga, cnta, busyb, doneb, passb, sigb, cntb} !== '0)
            $display("FAIL reset_small: got %h want 0",
                     {busya, donea, passa, siga, cnta, busyb, doneb, passb, sigb, cntb});
        else n_pass++;
        n_total++;
        if ({busyc, donec, passc, sigc, cntc} !== '0)
            $display("FAIL reset_dut17: got %h want 0", {busyc, donec, passc, sigc, cntc});
        else n_pass++;
        st0 = 0; v0 = 0; d0 = '0;
        idle_small();
        reset_n = 1;
        cyc0();
    endtask

    task automatic test_idle_valid();
        for (int i = 0; i < 6; i++) begin
            v0 = 1; d0 = 7'($urandom);
            cyc0();
            n_total++;
            if ({busy0, done0, pass0, sig0, cnt0} !== exp0())
                $display("FAIL idle_valid[%0d]: got %h want %h", i, {busy0, done0, pass0, sig0, cnt0}, exp0());
            else n_pass++;
        end
        v0 = 0;
    endtask

    task automatic test_zero_run();
        st0 = 1; v0 = 0; d0 = '0;
        cyc0();
        st0 = 0;
        n_total++;
        if (busy0 !== 1'b1 || done0 !== 1'b0 || sig0 !== 16'h0 || cnt0 !== 7'd0)
            $display("FAIL zero_start: got busy=%b done=%b sig=%h cnt=%0d want busy=1 done=0 sig=0 cnt=0",
                     busy0, done0, sig0, cnt0);
        else n_pass++;
        for (int i = 0; i < NP0; i++) begin
            v0 = 1; d0 = '0;
            cyc0();
            if (i == NP0 - 2) begin
                n_total++;
                if (done0 !== 1'b0 || busy0 !== 1'b1 || cnt0 !== 7'd126)
                    $display("FAIL zero_penult: got done=%b busy=%b cnt=%0d want done=0 busy=1 cnt=126",
                             done0, busy0, cnt0);
                else n_pass++;
            end
        end
        v0 = 0;
        n_total++;
        if (done0 !== 1'b1 || pass0 !== 1'b1 || busy0 !== 1'b0)
            $display("FAIL zero_done: got done=%b pass=%b busy=%b want 1 1 0", done0, pass0, busy0);
        else n_pass++;
        n_total++;
        if (sig0 !== 16'h0000 || cnt0 !== 7'd127)
            $display("FAIL zero_final: got sig=%h cnt=%0d want sig=0000 cnt=127", sig0, cnt0);
        else n_pass++;
    endtask

    task automatic test_random_run();
        int guard;
        st0 = 1;
        cyc0();
        st0 = 0;
        guard = 0;
        while (!m_done && guard < 3000) begin
            v0 = ($urandom_range(0, 3) != 0);
            d0 = 7'($urandom);
            st0 = ($urandom_range(0, 30) == 0);
            cyc0();
            guard++;
            n_total++;
            if ({busy0, done0, pass0, sig0, cnt0} !== exp0())
                $display("FAIL rand_cycle[%0d]: got %h want %h", guard, {busy0, done0, pass0, sig0, cnt0}, exp0());
            else n_pass++;
        end
        st0 = 0;
        n_total++;
        if (done0 !== 1'b1)
            $display("FAIL rand_timeout: got done=%b want 1 within bound", done0);
        else n_pass++;
        for (int i = 0; i < 5; i++) begin
            v0 = 1; d0 = 7'($urandom);
            cyc0();
            n_total++;
            if ({busy0, done0, pass0, sig0, cnt0} !== exp0())
                $display("FAIL done_hold[%0d]: got %h want %h", i, {busy0, done0, pass0, sig0, cnt0}, exp0());
            else n_pass++;
        end
        v0 = 0;
    endtask

    task automatic test_start_in_done();
        st0 = 1; v0 = 1; d0 = 7'h3C;
        cyc0();
        st0 = 0; v0 = 0;
        n_total++;
        if (done0 !== 1'b0 || busy0 !== 1'b1 || sig0 !== 16'h0 || cnt0 !== 7'd0)
            $display("FAIL restart: got done=%b busy=%b sig=%h cnt=%0d want 0 1 0000 0",
                     done0, busy0, sig0, cnt0);
        else n_pass++;
        for (int i = 0; i < 10; i++) begin
            v0 = 1; d0 = 7'($urandom);
            cyc0();
        end
        st0 = 1; v0 = 1; d0 = 7'($urandom);
        cyc0();
        st0 = 0; v0 = 0;
        n_total++;
        if (cnt0 !== 7'd11 || sig0 !== m_sig || busy0 !== 1'b1)
            $display("FAIL mid_start: got cnt=%0d sig=%h busy=%b want cnt=11 sig=%h busy=1",
                     cnt0, sig0, busy0, m_sig);
        else n_pass++;
    endtask

    task automatic test_reset_mid_run();
        int got;
        got = 0;
        while (got < 50) begin
            v0 = ($urandom_range(0, 4) != 0); d0 = 7'($urandom);
            cyc0();
            if (v0) got++;
        end
        v0 = 0;
        n_total++;
        if (cnt0 !== 7'd61 || busy0 !== 1'b1)
            $display("FAIL pre_abort: got cnt=%0d busy=%b want 61 1", cnt0, busy0);
        else n_pass++;
        reset_n = 0; v0 = 1; st0 = 1; d0 = 7'h7F;
        cyc0();
        reset_n = 1; v0 = 0; st0 = 0;
        n_total++;
        if ({busy0, done0, pass0, sig0, cnt0} !== 26'd0)
            $display("FAIL abort: got %h want 0", {busy0, done0, pass0, sig0, cnt0});
        else n_pass++;
        cyc0();
        test_zero_run();
    endtask

    task automatic test_small_runs();
        logic [6:0]  vec [4];
        logic [15:0] want;
        int          idx, guard;
        // 4-pattern DUT: fixed vector then random vectors with gaps
        for (int r = 0; r < 6; r++) begin
            want = '0;
            for (int k = 0; k < 4; k++) begin
                vec[k] = (r == 0) ? ((k == 0) ? 7'h01 : 7'h00) : 7'($urandom);
                want   = misr_step(want, vec[k]);
            end
            sta = 1; tick(); sta = 0;
            idx = 0; guard = 0;
            while (idx < 4 && guard < 100) begin
                va = ($urandom_range(0, 2) != 0);
                da = va ? vec[idx] : 7'($urandom);
                tick();
                if (va) idx++;
                guard++;
            end
            va = 0;
            n_total++;
            if (siga !== want || donea !== 1'b1 || passa !== (want == 16'h0) || cnta !== 3'd4 || busya !== 1'b0)
                $display("FAIL np4_run[%0d]: got sig=%h done=%b pass=%b cnt=%0d busy=%b want sig=%h done=1 pass=%b cnt=4 busy=0",
                         r, siga, donea, passa, cnta, busya, want, (want == 16'h0));
            else n_pass++;
            if (r == 0) begin
                n_total++;
                if (siga !== 16'h0008)
                    $display("FAIL np4_vector: got %h want 0008", siga);
                else n_pass++;
            end
        end
        // 1-pattern DUT
        stb = 1; tick(); stb = 0;
        n_total++;
        if (busyb !== 1'b1 || doneb !== 1'b0)
            $display("FAIL np1_busy: got busy=%b done=%b want 1 0", busyb, doneb);
        else n_pass++;
        vb = 1; db = 7'h7F; tick(); vb = 0;
        n_total++;
        if (sigb !== 16'h007F || doneb !== 1'b1 || passb !== 1'b0 || cntb !== 1'b1 || busyb !== 1'b0)
            $display("FAIL np1_run: got sig=%h done=%b pass=%b cnt=%0d busy=%b want 007F 1 0 1 0",
                     sigb, doneb, passb, cntb, busyb);
        else n_pass++;
        // 17-pattern DUT: feedback wraps into the tap positions, gaps must not matter
        stc = 1; tick(); stc = 0;
        idx = 0; guard = 0;
        while (idx < 17 && guard < 200) begin
            vc = ($urandom_range(0, 1) != 0);
            dc = vc ? ((idx == 0) ? 7'h01 : 7'h00) : 7'($urandom);
            tick();
            if (vc) idx++;
            guard++;
        end
        vc = 0;
        n_total++;
        if (sigc !== 16'h1021 || donec !== 1'b1 || passc !== 1'b1 || cntc !== 5'd17)
            $display("FAIL np17_run: got sig=%h done=%b pass=%b cnt=%0d want 1021 1 1 17",
                     sigc, donec, passc, cntc);
        else n_pass++;
    endtask

    initial begin
        reset_n = 0;
        st0 = 0; v0 = 0; d0 = '0;
        idle_small();
        model_step(0, 0, 0, '0);
        test_reset();
        test_idle_valid();
        test_zero_run();
        test_random_run();
        test_start_in_done();
        test_reset_mid_run();
        test_small_runs();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/misr_response_analyzer.md
# misr_response_analyzer

Output response analyzer for the BIST loop. It sits directly downstream of the circuit under test, which is itself fed by the 7-bit LFSR pattern generator. It compacts one CUT response word per valid cycle into a multiple-input signature register (MISR). After a programmed number of patterns it compares the final signature against a golden value and reports pass/fail.

## Interface
Parameters:
- `IN_LEN`, default 7: CUT response width; must satisfy `IN_LEN <= SIG_LEN`.
- `SIG_LEN`, default 16: MISR width.
- `NUM_PATTERNS`, default 127: responses compacted per run; matches the LFSR period; must be ≥ 1.
- `GOLDEN_SIG`, default `16'h0000`: expected final signature; overridden per CUT.

Ports:
- `clk`, input, 1: single clock; all logic on its rising edge.
- `reset_n`, input, 1: reset is synchronous and active-low.
- `start`, input, 1: one-cycle pulse that begins a run.
- `in_valid`, input, 1: `din` carries a response this cycle (driven by the LFSR's `out_valid` path, aligned to the CUT output).
- `din`, input, `IN_LEN`: CUT response word.
- `busy`, output, 1: run in progress (state is COMPACT).
- `done`, output, 1: run finished; `signature` and `pass` are final.
- `pass`, output, 1: final signature equals `GOLDEN_SIG`; meaningful only while `done`=1.
- `signature`, output, `SIG_LEN`: current MISR contents.
- `pat_cnt`, output, `$clog2(NUM_PATTERNS+1)`: responses accepted in the current run.

## Operation
- States:
  - IDLE: after reset.
  - COMPACT: accepting responses.
  - DONE: result held.
- IDLE/DONE + `start` → COMPACT. On that edge, `signature` and `pat_cnt` clear to 0, and `done` and `pass` clear to 0.
- COMPACT + `start`: ignored. `in_valid` in IDLE or DONE: ignored; no register changes.
- COMPACT + `in_valid`: `signature` ← MISR next value, and `pat_cnt` ← `pat_cnt`+1.
- COMPACT + `in_valid` + `pat_cnt`==`NUM_PATTERNS`-1: the final response. On that edge:
  - go to DONE;
  - `done` ← 1;
  - `pass` ← (MISR next value == `GOLDEN_SIG`).
- COMPACT + no `in_valid`: hold all registers. There is no timeout.
- DONE holds `signature`, `pat_cnt`, `done` and `pass` until `start` or reset.
- MISR next value, with tap mask `TAP` = `16'h1021` (x^16+x^12+x^5+1):
  - bit 0 = `sig[15]` ^ `din[0]`;
  - bit i, for 1 ≤ i ≤ 15 = `sig[i-1]` ^ (`TAP[i]` & `sig[15]`) ^ (`din[i]` if i < `IN_LEN`, otherwise 0).
- No arithmetic beyond the XOR logic and the counter. `pat_cnt` never exceeds `NUM_PATTERNS` and never wraps.

## Timing
- Reset (`reset_n`=0 at an edge): state IDLE; `busy`=0, `done`=0, `pass`=0, `signature`=0, `pat_cnt`=0. Reset overrides `start` and `in_valid` at the same edge.
- Reset mid-run: the run is aborted, and outputs take their reset values on the next cycle.
- Latency: `signature` reflects a response 1 cycle after its `in_valid`.
- `done` and `pass` assert together 1 cycle after the final accepted `in_valid`.
- `busy` goes high 1 cycle after `start` and drops in the same cycle that `done` rises.
- `start` in DONE: `done` falls 1 cycle later, and `busy` rises in that same cycle.
- Back-to-back `in_valid` at full rate is supported; there is no backpressure.
- All outputs are registered.

## Structure
- Shared package `bist_pkg`:
  - state enum (IDLE, COMPACT, DONE);
  - `MISR_TAP_CCITT` = `16'h1021`;
  - default `GOLDEN_SIG`.
- Sub-module `misr_core`, parameterized by `IN_LEN`, `SIG_LEN` and `TAP`. It holds the signature register with `clr` and `en` inputs and exposes its next value for the pass compare.
- The top level holds the FSM, the pattern counter and the compare register.

## Test plan
- Run with `din`=0 for all 127 patterns, `GOLDEN_SIG`=0 → `signature`=`16'h0000`, `pass`=1. `done` rises 1 cycle after the 127th `in_valid`, and `pat_cnt`=127.
- `NUM_PATTERNS`=4; `din` = `7'h01`, then 0, 0, 0 → `signature`=`16'h0008`.
- `NUM_PATTERNS`=1, `din`=`7'h7F` → `signature`=`16'h007F`, `pass`=0 with the default golden.
- Feedback check: `NUM_PATTERNS`=17; `din` = `7'h01`, then 16 zeros → `signature`=`16'h1021`. Insert `in_valid` gaps; the result is unchanged.
- `start` pulsed mid-COMPACT → ignored, `pat_cnt` continues. `start` in DONE → `signature` and `pat_cnt` clear to 0, `done` falls next cycle.
- `reset_n` low at pattern 50 → next cycle IDLE with all outputs 0. A subsequent full run matches the first scenario.
